alu_share_sequencer: RTL and testbench
======================================

// Module: alu_share_sequencer
// PURPOSE
//  Shares the single ALU between two requesters (req0, req1) and sequences multi-cycle ops.
//  Round-robin arbitration, valid/ready on each request port, one response port with backpressure.
//  Sits between issue logic and the ALU; the ALU is combinational except MUL, which needs operands held for MUL_LAT cycles.
// PARAMETERS
//  DATA_W   32  operand/result width
//  CTRL_W   3   ALU control width (matches ALU_Control output)
//  MUL_LAT  3   cycles operands are held for ALU_MUL (>=1); all other ops take 1
// PORTS
//  clk_i          in   1       clock; all state changes on rising edge
//  rst_i          in   1       reset, synchronous, active-high
//  req0_valid_i   in   1       requester 0 has an op
//  req0_ready_o   out  1       requester 0 accepted this cycle (valid & ready)
//  req0_ctrl_i    in   CTRL_W  ALU_* op code
//  req0_a_i       in   DATA_W  operand A
//  req0_b_i       in   DATA_W  operand B
//  req1_*         --   --      same as req0_* for requester 1
//  alu_ctrl_o     out  CTRL_W  to ALU control input
//  alu_a_o        out  DATA_W  to ALU operand A
//  alu_b_o        out  DATA_W  to ALU operand B
//  alu_res_i      in   DATA_W  ALU result
//  resp_valid_o   out  1       result available
//  resp_ready_i   in   1       consumer takes result
//  resp_id_o      out  1       requester that owns the result (0/1)
//  resp_data_o    out  DATA_W  result
//  resp_err_o     out  1       op code was not a defined ALU_* code
// BEHAVIOUR
//  FSM: IDLE -> EXEC -> DONE -> IDLE. Reset (any state): IDLE, cnt=0, last_grant=1, all outputs 0.
//  IDLE: grant = sole valid requester; both valid -> requester != last_grant.
//   reqN_ready_o = (state==IDLE) & grant==N, combinational; 0 in EXEC/DONE.
//   On accept: latch ctrl/a/b/id; cnt <= (ctrl==ALU_MUL) ? MUL_LAT-1 : 0; err <= undefined code; -> EXEC.
//   Requesters may drop valid before accept; nothing latched, no state change.
//  EXEC: alu_*_o drive latched values; cnt!=0 -> cnt-1; cnt==0 -> resp_data <= alu_res_i, -> DONE.
//  DONE: resp_valid_o=1, resp_id/data/err stable; resp_ready_i=1 -> last_grant <= id, -> IDLE.
//   No new accept in the DONE cycle even if resp_ready_i=1 (accept earliest next cycle).
//  Latency: accept at cycle T -> resp_valid_o at T+1+lat (lat=MUL_LAT for MUL, else 1).
//  alu_*_o hold last latched values outside EXEC (0 after reset); result only sampled in EXEC.
//  Undefined code: executed with lat 1, resp_err_o=1, data = whatever ALU returns.
//  Reset mid-EXEC/DONE: in-flight op discarded, no response emitted.
//  resp_valid_o never drops without resp_ready_i; resp_* never change while valid.
// STRUCTURE
//  ALU_* op codes and funct constants stay in header.v (shared); state encoding as local params.
//  One sub-module natural: alu_rr_arb2 (2-way round-robin grant from valids + last_grant).
//  Target 150-250 lines total.
// TESTING
//  Reset then req0 ADD a=5,b=7 -> ready0 same cycle, resp valid 2 cycles later, id=0, data=12, err=0.
//  Both valid after reset (req0 SUB 9-4, req1 XOR 0xF0^0x0F) -> req0 first (data 5), then req1 (0xFF).
//  req1 MUL 6*7, MUL_LAT=3 -> alu_ctrl/a/b stable 3 cycles, resp at T+4, data=42, id=1.
//  resp_ready_i held 0 for 5 cycles with req0/req1 valid -> both ready low, resp stable, then drain.
//  rst_i asserted in EXEC of a MUL -> next cycle IDLE, resp_valid_o=0, last_grant=1, no response.
//  Undefined ctrl code -> resp_err_o=1, latency 1+1, subsequent ADD returns err=0.

Source files
------------

// File: rtl/alu_share_sequencer_pkg.sv
// ALU op codes and helpers shared by the ALU share sequencer.
// Codes match the ALU_Control encoding driven into the ALU.
package alu_share_sequencer_pkg;

  localparam int ALU_CTRL_W = 3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_MUL = 3'd6;

  // Codes above ALU_MUL are unassigned.
  function automatic logic alu_op_defined(
    input logic [ALU_CTRL_W-1:0] op
  );
    return op <= ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_share_sequencer_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright,
// a tie goes to whoever was not served last.
module alu_rr_arb2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last,
  output logic o_gnt_vld,
  output logic o_gnt_id
);

  assign o_gnt_vld = i_valid0 | i_valid1;
  assign o_gnt_id  = (i_valid0 & i_valid1) ? ~i_last
                                           : i_valid1;

endmodule

// File: rtl/alu_share_sequencer.sv
// Shares one ALU between two requesters and holds operands
// for multi-cycle MUL; single response port with backpressure.
module alu_share_sequencer
  import alu_share_sequencer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = ALU_CTRL_W,
  parameter int MUL_LAT = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [CTRL_W-1:0] req0_ctrl_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [CTRL_W-1:0] req1_ctrl_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic              resp_id_o,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_err_o
);

  localparam int CNT_W = $clog2(MUL_LAT) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_last;
  logic                r_id;
  logic                r_err;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_data;

  logic                w_gnt_vld;
  logic                w_gnt_id;
  logic                w_idle;
  logic                w_acc;
  logic [CTRL_W-1:0]   w_ctrl;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;

  alu_rr_arb2 u_arb (
    .i_valid0  (req0_valid_i),
    .i_valid1  (req1_valid_i),
    .i_last    (r_last),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_id  (w_gnt_id)
  );

  assign w_idle = (r_state == S_IDLE);
  assign w_acc  = w_idle & w_gnt_vld;

  assign req0_ready_o = w_acc & ~w_gnt_id;
  assign req1_ready_o = w_acc &  w_gnt_id;

  assign w_ctrl = w_gnt_id ? req1_ctrl_i : req0_ctrl_i;
  assign w_a    = w_gnt_id ? req1_a_i    : req0_a_i;
  assign w_b    = w_gnt_id ? req1_b_i    : req0_b_i;

  // ALU inputs simply hold the last accepted op.
  assign alu_ctrl_o   = r_ctrl;
  assign alu_a_o      = r_a;
  assign alu_b_o      = r_b;

  assign resp_valid_o = (r_state == S_DONE);
  assign resp_id_o    = r_id;
  assign resp_data_o  = r_data;
  assign resp_err_o   = r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_err   <= 1'b0;
      r_ctrl  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_ctrl  <= w_ctrl;
            r_a     <= w_a;
            r_b     <= w_b;
            r_id    <= w_gnt_id;
            r_err   <= ~alu_op_defined(w_ctrl);
            r_cnt   <= (w_ctrl == ALU_MUL)
                       ? CNT_W'(MUL_LAT - 1)
                       : '0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_data  <= alu_res_i;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready_i) begin
            r_last  <= r_id;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Scoreboard bench for alu_share_sequencer: directed cases
// followed by randomized traffic against a reference model.
module tb_alu_share_sequencer;
  import alu_share_sequencer_pkg::*;

  localparam int MUL_LAT = 3;

  typedef struct {
    bit          id;
    logic [31:0] data;
    bit          err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv [2];
  logic [2:0]  rc [2];
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic        rdy0, rdy1;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        resp_valid, resp_ready;
  logic        resp_id, resp_err;
  logic [31:0] resp_data;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pop_cyc = -1;
  int   rr_mode = 0;
  bit   tb_last = 1'b1;
  bit   seen = 1'b0;
  exp_t q[$];

  // Reference ALU behaviour; unassigned codes give a fixed pattern.
  function automatic logic [31:0] alu_fn(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      ALU_MUL: return a * b;
      default: return 32'hDEAD_BEEF ^ a ^ b;
    endcase
  endfunction

  assign alu_res = alu_fn(alu_ctrl, alu_a, alu_b);

  alu_share_sequencer #(
    .DATA_W (32),
    .CTRL_W (3),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req0_valid_i(rv[0]),
    .req0_ready_o(rdy0),
    .req0_ctrl_i (rc[0]),
    .req0_a_i    (ra[0]),
    .req0_b_i    (rb[0]),
    .req1_valid_i(rv[1]),
    .req1_ready_o(rdy1),
    .req1_ctrl_i (rc[1]),
    .req1_a_i    (ra[1]),
    .req1_b_i    (rb[1]),
    .alu_ctrl_o  (alu_ctrl),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_res_i   (alu_res),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_id_o   (resp_id),
    .resp_data_o (resp_data),
    .resp_err_o  (resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h cyc=%0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic rdy(input int n);
    return (n == 0) ? rdy0 : rdy1;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = ($urandom_range(0, 3) != 0);
      default: resp_ready = 1'b0;
    endcase
  end

  // Acceptance side: arbitration rules and expected responses.
  always @(negedge clk) begin
    int   en;
    exp_t e;
    if (!rst) begin
      if (rdy0 && rdy1) chk("two_ready", 1, 0);
      if (rdy0 && !rv[0]) chk("rdy0_no_valid", 1, 0);
      if (rdy1 && !rv[1]) chk("rdy1_no_valid", 1, 0);
      if (q.size() != 0)
        chk("busy_ready", {31'b0, rdy0 | rdy1}, 0);
      if (q.size() == 0 && pop_cyc != cyc &&
          (rv[0] || rv[1])) begin
        en = (rv[0] && rv[1]) ? int'(!tb_last)
                              : (rv[1] ? 1 : 0);
        chk($sformatf("grant%0d", en), rdy(en), 1);
      end
      for (int n = 0; n < 2; n++) begin
        if (rv[n] && rdy(n)) begin
          e.id   = (n == 1);
          e.data = alu_fn(rc[n], ra[n], rb[n]);
          e.err  = (rc[n] > ALU_MUL);
          e.due  = cyc + 1 +
                   ((rc[n] == ALU_MUL) ? MUL_LAT : 1);
          q.push_back(e);
        end
      end
    end
  end

  // Response side: pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 1'b0;
    end else if (resp_valid) begin
      if (q.size() == 0) begin
        chk("spurious_resp", 1, 0);
      end else begin
        e = q[0];
        if (!seen) begin
          chk("latency", cyc, e.due);
          seen = 1'b1;
        end
        chk("resp_id", resp_id, e.id);
        chk("resp_data", resp_data, e.data);
        chk("resp_err", resp_err, e.err);
        if (resp_ready) begin
          void'(q.pop_front());
          seen    = 1'b0;
          tb_last = e.id;
          pop_cyc = cyc;
        end
      end
    end else if (seen) begin
      chk("valid_dropped", 0, 1);
      seen = 1'b0;
    end
  end

  task automatic issue(
    input int n, input logic [2:0] op,
    input logic [31:0] a, input logic [31:0] b,
    input int maxw, input bit must
  );
    bit ok = 1'b0;
    rv[n] = 1'b1;
    rc[n] = op;
    ra[n] = a;
    rb[n] = b;
    for (int k = 0; k < maxw && !ok; k++) begin
      @(negedge clk);
      if (rdy(n)) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    rv[n] = 1'b0;
    if (must) chk($sformatf("accept%0d", n), ok, 1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      if (q.size() == 0 && !resp_valid) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("drain", done, 1);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    q.delete();
    tb_last = 1'b1;
    seen    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic driver(input int n);
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 120; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0)
        issue(n, op, a, b, 1, 1'b0);
      else
        issue(n, op, a, b, 300, 1'b1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 2; n++) begin
      rv[n] = 1'b0;
      rc[n] = '0;
      ra[n] = '0;
      rb[n] = '0;
    end
    resp_ready = 1'b0;
    do_reset();

    @(negedge clk);
    chk("rst_valid", resp_valid, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_ctrl", alu_ctrl, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_rdy", {31'b0, rdy0 | rdy1}, 0);
    @(posedge clk);
    #1;

    issue(0, ALU_ADD, 5, 7, 200, 1'b1);
    wait_idle();

    do_reset();
    fork
      issue(0, ALU_SUB, 9, 4, 200, 1'b1);
      issue(1, ALU_XOR, 32'hF0, 32'h0F, 200, 1'b1);
    join
    wait_idle();

    issue(1, ALU_MUL, 6, 7, 200, 1'b1);
    for (int k = 0; k < MUL_LAT; k++) begin
      @(negedge clk);
      chk("mul_ctrl", alu_ctrl, ALU_MUL);
      chk("mul_a", alu_a, 6);
      chk("mul_b", alu_b, 7);
      @(posedge clk);
      #1;
    end
    wait_idle();

    rr_mode = 2;
    fork
      issue(0, ALU_ADD, 1, 2, 200, 1'b1);
      issue(1, ALU_OR, 32'h30, 32'h03, 200, 1'b1);
      begin
        repeat (4) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_valid", resp_valid, 1);
          chk("bp_rdy", {31'b0, rdy0 | rdy1}, 0);
        end
        @(posedge clk);
        #1;
        rr_mode = 0;
      end
    join
    wait_idle();

    issue(0, ALU_AND, 32'hFF, 32'h0F, 200, 1'b1);
    wait_idle();
    issue(1, ALU_MUL, 6, 7, 200, 1'b1);
    rst     = 1'b1;
    q.delete();
    tb_last = 1'b1;
    seen    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", resp_valid, 0);
    chk("midrst_ctrl", alu_ctrl, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    fork
      issue(0, ALU_SUB, 20, 3, 200, 1'b1);
      issue(1, ALU_SLT, 32'hFFFF_FFFF, 1, 200, 1'b1);
    join
    wait_idle();

    issue(0, 3'd7, 3, 4, 200, 1'b1);
    wait_idle();
    issue(0, ALU_ADD, 1, 1, 200, 1'b1);
    wait_idle();

    rr_mode = 1;
    fork
      driver(0);
      driver(1);
    join
    rr_mode = 0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
